// File: rtl/inst_axi_rd_bridge.sv
// Read-only bridge from the fetch stage's SRAM-like instruction port to an AXI read master.
// Single-beat AR per request, up to MAX_OUT reads in flight, in-order data return.
module inst_axi_rd_bridge #(
  parameter logic [3:0] ARID    = 4'd0,
  parameter int         MAX_OUT = 2,
  parameter int         CNT_W   = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        bus_err
);

  localparam logic [0:0] AR_IDLE = 1'b0;
  localparam logic [0:0] AR_SEND = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      araddr_q;
  logic [1:0]       arsize_q;
  logic             rready_q;
  logic             accept, beat_done;

  // Write-side fields and rid carry no information for an in-order read-only port.
  logic unused_inputs;
  assign unused_inputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rid};

  // Accept only from IDLE so arready never reaches addr_ok combinationally.
  assign accept = resetn & inst_sram_req & (state_q == AR_IDLE) & (cnt_q < CNT_W'(MAX_OUT));
  assign inst_sram_addr_ok = accept;

  // Beats with nothing outstanding are swallowed silently.
  assign inst_sram_data_ok = resetn & rready_q & rvalid & (cnt_q != '0);
  assign inst_sram_rdata   = rdata;
  assign bus_err           = inst_sram_data_ok & (rresp != 2'b00);
  assign beat_done         = inst_sram_data_ok & rlast;

  assign arid    = ARID;
  assign araddr  = araddr_q;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, arsize_q};
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = (state_q == AR_SEND);
  assign rready  = rready_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      AR_IDLE: if (accept)  state_d = AR_SEND;
      AR_SEND: if (arready) state_d = AR_IDLE;
      default:              state_d = AR_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({accept, beat_done})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= AR_IDLE;
      cnt_q    <= '0;
      araddr_q <= '0;
      arsize_q <= '0;
      rready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rready_q <= 1'b1;
      if (accept) begin
        araddr_q <= inst_sram_addr;
        arsize_q <= inst_sram_size;
      end
    end
  end

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Bench for inst_axi_rd_bridge: directed scenarios then a randomized AXI slave,
// all checked every cycle against a queue-based model of the bridge's contract.
module tb_inst_axi_rd_bridge;
  localparam int MAX_OUT = 2;

  logic        clk = 1'b0, resetn = 1'b0;
  logic        inst_sram_req = 1'b0, inst_sram_wr = 1'b0;
  logic [1:0]  inst_sram_size = 2'd2;
  logic [3:0]  inst_sram_wstrb = 4'd0;
  logic [31:0] inst_sram_addr = '0, inst_sram_wdata = '0;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready = 1'b0;
  logic [3:0]  rid = 4'd0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = 2'd0;
  logic        rlast = 1'b1, rvalid = 1'b0, rready, bus_err;

  always #5 clk = ~clk;

  inst_axi_rd_bridge #(.ARID(4'd0), .MAX_OUT(MAX_OUT), .CNT_W(2)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .bus_err(bus_err)
  );

  int nvec = 0, nerr = 0;

  // Reference model: outstanding count, one pending AR slot, acceptance-order address queue.
  int          m_cnt = 0;
  bit          m_pend = 1'b0, m_rready = 1'b0, chk_ord = 1'b0;
  logic [31:0] m_araddr = '0;
  logic [1:0]  m_arsize = '0;
  logic [31:0] ord[$];

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rq, input logic [31:0] ad, input logic [1:0] sz, input bit ary,
                      input bit rv, input logic [31:0] rd, input logic [1:0] rr, input bit rl,
                      output bit acc, output bit arhs, output logic [31:0] arhs_addr);
    bit e_aok, e_dok;
    inst_sram_req = rq; inst_sram_addr = ad; inst_sram_size = sz; arready = ary;
    rvalid = rv; rdata = rd; rresp = rr; rlast = rl;
    @(negedge clk);
    e_aok = resetn && !m_pend && rq && (m_cnt < MAX_OUT);
    e_dok = resetn && rv && (m_cnt != 0);
    chk("addr_ok", 32'(inst_sram_addr_ok), 32'(e_aok));
    chk("data_ok", 32'(inst_sram_data_ok), 32'(e_dok));
    chk("bus_err", 32'(bus_err), 32'(e_dok && rr != 2'b00));
    chk("arvalid", 32'(arvalid), 32'(m_pend));
    chk("araddr", araddr, m_araddr);
    chk("arsize", 32'(arsize), 32'({1'b0, m_arsize}));
    chk("rready", 32'(rready), 32'(m_rready));
    if (e_dok) chk("rdata", inst_sram_rdata, rd);
    if (e_dok && chk_ord && ord.size() > 0) chk("order", inst_sram_rdata, mem(ord[0]));
    @(posedge clk);
    acc = e_aok;
    arhs = resetn && m_pend && ary;
    arhs_addr = m_araddr;
    if (!resetn) begin
      m_cnt = 0; m_pend = 1'b0; m_rready = 1'b0; m_araddr = '0; m_arsize = '0; ord.delete();
    end else begin
      if (e_dok && ord.size() > 0) void'(ord.pop_front());
      if (e_dok && rl) m_cnt--;
      if (e_aok) begin
        m_cnt++; ord.push_back(ad); m_pend = 1'b1; m_araddr = ad; m_arsize = sz;
      end else if (m_pend && ary) m_pend = 1'b0;
      m_rready = 1'b1;
    end
    #1;
  endtask

  task automatic st(input bit rq, input logic [31:0] ad, input bit ary, input bit rv,
                    input logic [31:0] rd, input logic [1:0] rr);
    bit a, h;
    logic [31:0] ha;
    step(rq, ad, 2'd2, ary, rv, rd, rr, 1'b1, a, h, ha);
  endtask

  initial begin
    bit a, h, hold;
    logic [31:0] ha, raddr;
    logic [31:0] slv[$];
    hold = 1'b0; raddr = '0;
    @(posedge clk); #1;

    // reset: no accepts or data even with req/rvalid high
    st(1, 32'h1c000000, 0, 1, 32'h11111111, 0);
    st(1, 32'h1c000000, 0, 1, 32'h11111111, 0);
    chk("arid", 32'(arid), 32'h0);
    chk("arlen", 32'(arlen), 32'h0);
    chk("arburst", 32'(arburst), 32'h1);
    chk("arlock_cache_prot", 32'({arlock, arcache, arprot}), 32'h0);
    resetn = 1'b1;

    // single fetch
    st(1, 32'h1c000000, 0, 0, 32'h0, 0);
    st(0, 32'h0, 1, 0, 32'h0, 0);
    st(0, 32'h0, 0, 0, 32'h0, 0);
    st(0, 32'h0, 0, 0, 32'h0, 0);
    st(0, 32'h0, 0, 1, 32'h02800c0c, 0);
    st(0, 32'h0, 0, 1, 32'h55555555, 0);        // stray beat, count back at zero

    // AR backpressure
    st(1, 32'h1c000010, 0, 0, 32'h0, 0);
    repeat (5) st(1, 32'h1c000014, 0, 0, 32'h0, 0);
    st(1, 32'h1c000014, 1, 0, 32'h0, 0);

    // full at MAX_OUT
    st(1, 32'h1c000014, 0, 0, 32'h0, 0);
    st(1, 32'h1c000018, 1, 0, 32'h0, 0);
    st(1, 32'h1c000018, 0, 0, 32'h0, 0);
    st(1, 32'h1c000018, 0, 1, 32'haaaa0001, 0);
    st(1, 32'h1c000018, 0, 0, 32'h0, 0);
    st(0, 32'h0, 1, 0, 32'h0, 0);
    st(1, 32'h1c00001c, 0, 0, 32'h0, 0);

    // simultaneous accept and return at cnt=1
    st(0, 32'h0, 0, 1, 32'haaaa0002, 0);
    st(1, 32'h1c00001c, 0, 1, 32'haaaa0003, 0);
    st(0, 32'h0, 1, 0, 32'h0, 0);
    st(1, 32'h1c000020, 0, 0, 32'h0, 0);
    st(0, 32'h0, 1, 0, 32'h0, 0);
    st(1, 32'h1c000024, 0, 0, 32'h0, 0);

    // error response, then clean beat
    st(0, 32'h0, 0, 1, 32'hdeadbeef, 2'b10);
    st(0, 32'h0, 0, 1, 32'hcafef00d, 0);
    st(0, 32'h0, 0, 0, 32'h0, 0);

    // rlast=0 beat delivers data but keeps the request outstanding
    st(1, 32'h1c000030, 1, 0, 32'h0, 0);
    st(0, 32'h0, 1, 0, 32'h0, 0);
    step(0, 32'h0, 2'd2, 0, 1, 32'h12340000, 0, 1'b0, a, h, ha);
    st(0, 32'h0, 0, 1, 32'h12340001, 0);
    st(0, 32'h0, 0, 1, 32'h12340002, 0);

    // reset mid-flight
    st(1, 32'h1c000040, 0, 0, 32'h0, 0);
    resetn = 1'b0;
    st(1, 32'h1c000044, 0, 1, 32'h77777777, 0);
    st(1, 32'h1c000044, 0, 1, 32'h77777777, 0);
    resetn = 1'b1;
    st(1, 32'h1c000048, 0, 1, 32'h88888888, 0);
    st(0, 32'h0, 1, 0, 32'h0, 0);
    st(0, 32'h0, 0, 1, 32'h99999999, 0);

    // randomized traffic against an in-order slave
    resetn = 1'b0;
    st(0, 32'h0, 0, 0, 32'h0, 0);
    resetn = 1'b1;
    chk_ord = 1'b1;
    for (int i = 0; i < 500; i++) begin
      bit rq, ary, rv;
      logic [1:0] rr;
      logic [31:0] rd;
      if (!hold) begin
        hold = ($urandom % 3) != 0;
        raddr = $urandom & 32'hffff_fffc;
      end
      rq  = hold;
      ary = ($urandom % 2) != 0;
      rv  = (slv.size() > 0) && (($urandom % 2) != 0);
      rd  = rv ? mem(slv[0]) : $urandom;
      rr  = (($urandom % 6) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      step(rq, raddr, 2'd2, ary, rv, rd, rr, 1'b1, a, h, ha);
      if (a) hold = 1'b0;
      if (h) slv.push_back(ha);
      if (rv) void'(slv.pop_front());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
